// File: rtl/mac_accumulator_pkg.sv
// Shared types and constants for the streaming MAC accumulator.
package mac_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam int ACC_W_DEF     = 72;
  localparam int MAX_TERMS_DEF = 256;
  localparam int CNT_W_DEF     = 16;

  localparam logic [63:0] SAT_POS_64 = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SAT_NEG_64 = 64'h8000_0000_0000_0000;

endpackage

// File: rtl/mac_accumulator_if.sv
// Product-in / group-result-out handshake bundle of the MAC accumulator.
interface mac_accumulator_if
  import mac_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic              in_valid;
  logic              in_ready;
  logic [63:0]       in_product;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_sat;
  logic              out_trunc;

  modport slave (
    input  in_valid, in_product, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_sat, out_trunc
  );

  modport master (
    output in_valid, in_product, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_sat, out_trunc
  );

endinterface

// File: rtl/mac_accumulator_sat_narrow.sv
// Combinational signed narrowing of the wide accumulator to 64 bits with clamp flag.
module sat_narrow
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] acc,
  output logic [63:0]      sum,
  output logic             sat
);

  // Value fits in 64 bits exactly when bit 63 and all guard bits agree.
  logic [ACC_W-64:0] upper;
  assign upper = acc[ACC_W-1:63];

  always_comb begin
    sum = acc[63:0];
    sat = 1'b0;
    if (!((&upper) || (~|upper))) begin
      sat = 1'b1;
      sum = acc[ACC_W-1] ? SAT_NEG_64 : SAT_POS_64;
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// Group dot-product accumulator: sums signed products per group and emits one
// saturated 64-bit result per group through a valid/ready output register.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int ACC_W     = ACC_W_DEF,
  parameter int MAX_TERMS = MAX_TERMS_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  mac_accumulator_if.slave  bus
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

  state_t             state_reg, state_next;
  logic [ACC_W-1:0]   acc_reg, acc_next, acc_sum, product_ext;
  logic [CNT_W-1:0]   cnt_reg, cnt_next, cnt_sum;
  logic               out_valid_reg;
  logic [63:0]        out_sum_reg;
  logic [CNT_W-1:0]   out_count_reg;
  logic               out_sat_reg, out_trunc_reg;
  logic               in_ready, accept, close;
  logic [63:0]        sat_sum;
  logic               sat_flag;

  assign in_ready    = ~out_valid_reg | bus.out_ready;
  assign accept      = bus.in_valid & in_ready;
  assign product_ext = {{(ACC_W-64){bus.in_product[63]}}, bus.in_product};

  // An EMPTY group starts fresh, so the held acc is ignored rather than cleared first.
  assign acc_sum = ((state_reg == EMPTY) ? '0 : acc_reg) + product_ext;
  assign cnt_sum = (state_reg == EMPTY) ? CNT_W'(1) : cnt_reg + CNT_W'(1);
  assign close   = accept & (bus.in_last | (cnt_sum == MAX_CNT));

  sat_narrow #(.ACC_W(ACC_W)) u_sat (
    .acc (acc_sum),
    .sum (sat_sum),
    .sat (sat_flag)
  );

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    if (accept) begin
      if (close) begin
        state_next = EMPTY;
        acc_next   = '0;
        cnt_next   = '0;
      end else begin
        state_next = ACCUM;
        acc_next   = acc_sum;
        cnt_next   = cnt_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
      acc_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
    end
  end

  // A close in the same cycle as a drain reloads the register and keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_sum_reg   <= '0;
      out_count_reg <= '0;
      out_sat_reg   <= 1'b0;
      out_trunc_reg <= 1'b0;
    end else if (close) begin
      out_valid_reg <= 1'b1;
      out_sum_reg   <= sat_sum;
      out_count_reg <= cnt_sum;
      out_sat_reg   <= sat_flag;
      out_trunc_reg <= ~bus.in_last;
    end else if (out_valid_reg && bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_sum   = out_sum_reg;
  assign bus.out_count = out_count_reg;
  assign bus.out_sat   = out_sat_reg;
  assign bus.out_trunc = out_trunc_reg;

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: directed group cases plus randomized
// products and backpressure against a wide-integer reference model.
module tb_mac_accumulator;

  localparam int MAXT = 4;
  localparam int CW   = 16;
  localparam int AW   = 72;

  localparam logic signed [127:0] MAXV = 128'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [127:0] MINV = -128'sh8000_0000_0000_0000;

  typedef struct {
    logic [63:0] sum;
    int          cnt;
    bit          sat;
    bit          trunc;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_accumulator_if #(.CNT_W(CW)) bus ();

  mac_accumulator #(.ACC_W(AW), .MAX_TERMS(MAXT), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  res_t exp_q[$];
  res_t cur;
  int   checks = 0;
  int   errors = 0;

  logic signed [127:0] msum;
  int   mcnt;
  bit   exp_valid;
  bit   acc_flag;
  bit   need_pop;
  bit   rand_rdy;
  bit   drain_now;
  bit   close_now;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  function automatic res_t mk(input logic signed [127:0] s, input int c, input bit tr);
    res_t r;
    r.cnt   = c;
    r.trunc = tr;
    if (s > MAXV) begin
      r.sum = 64'h7FFF_FFFF_FFFF_FFFF;
      r.sat = 1'b1;
    end else if (s < MINV) begin
      r.sum = 64'h8000_0000_0000_0000;
      r.sat = 1'b1;
    end else begin
      r.sum = s[63:0];
      r.sat = 1'b0;
    end
    return r;
  endfunction

  // Reference model: plain running sum, term counter and pending-result flag.
  initial begin
    msum = 0;
    mcnt = 0;
    exp_valid = 0;
    forever begin
      @(posedge clk);
      acc_flag  = 1'b0;
      close_now = 1'b0;
      if (!rst_n) begin
        msum = 0;
        mcnt = 0;
        exp_valid = 0;
        exp_q.delete();
      end else begin
        drain_now = exp_valid && bus.out_ready;
        if (bus.in_valid && (!exp_valid || bus.out_ready)) begin
          acc_flag = 1'b1;
          msum = msum + $signed({{64{bus.in_product[63]}}, bus.in_product});
          mcnt++;
          if (bus.in_last || mcnt == MAXT) begin
            close_now = 1'b1;
            exp_q.push_back(mk(msum, mcnt, !bus.in_last));
            msum = 0;
            mcnt = 0;
          end
        end
        if (close_now) exp_valid = 1'b1;
        else if (drain_now) exp_valid = 1'b0;
      end
    end
  end

  // Monitor: compares presented results against the queue at mid-cycle.
  initial begin
    need_pop = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        need_pop = 1'b1;
      end else begin
        chk("out_valid", 64'(bus.out_valid), 64'(exp_valid));
        chk("in_ready", 64'(bus.in_ready), 64'(!exp_valid || bus.out_ready));
        if (bus.out_valid) begin
          if (need_pop) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL spurious_result actual sum=%h required none", bus.out_sum);
            end else begin
              cur = exp_q.pop_front();
              need_pop = 1'b0;
              $display("RESULT sum=%h count=%0d sat=%0d trunc=%0d",
                       bus.out_sum, bus.out_count, bus.out_sat, bus.out_trunc);
            end
          end
          if (!need_pop) begin
            chk("out_sum", bus.out_sum, cur.sum);
            chk("out_count", 64'(bus.out_count), 64'(cur.cnt));
            chk("out_sat", 64'(bus.out_sat), 64'(cur.sat));
            chk("out_trunc", 64'(bus.out_trunc), 64'(cur.trunc));
          end
          if (bus.out_ready) need_pop = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input logic [63:0] p, input bit l);
    int n;
    n = 0;
    bus.in_valid   = 1'b1;
    bus.in_product = p;
    bus.in_last    = l;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!acc_flag && n < 200);
    if (!acc_flag) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout actual=not_accepted required=accepted");
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_out_sum"}, bus.out_sum, 64'd0);
    chk({tag, "_out_count"}, 64'(bus.out_count), 64'd0);
    chk({tag, "_out_sat"}, 64'(bus.out_sat), 64'd0);
    chk({tag, "_out_trunc"}, 64'(bus.out_trunc), 64'd0);
  endtask

  initial begin
    int a, b;
    longint p;
    rand_rdy       = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_product = '0;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b1;
    idle(3);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    idle(1);

    beat(64'sd6, 0); beat(-64'sd10, 0); beat(64'sd100, 1);
    idle(2);

    repeat (3) beat(64'h4000_0000_0000_0000, 0);
    beat(64'h4000_0000_0000_0000, 1);
    idle(1);
    repeat (3) beat(64'hC000_0000_0000_0000, 0);
    beat(64'hC000_0000_0000_0000, 1);
    idle(2);

    beat(64'sd5, 1); beat(64'sd7, 1); beat(64'sd9, 1);
    idle(2);
    bus.out_ready = 1'b0;
    fork
      begin beat(64'sd5, 1); beat(64'sd7, 1); beat(64'sd9, 1); end
      begin idle(6); bus.out_ready = 1'b1; end
    join
    idle(2);

    repeat (4) beat(64'sd1, 0);
    beat(64'sd1, 1);
    idle(2);

    beat(64'sd10, 0); beat(64'sd20, 0);
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    beat(64'sd3, 1);
    idle(2);

    beat(64'sd1000, 0);
    idle(5);
    beat(-64'sd1, 1);
    idle(2);

    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        a = 32'h8000_0000;
        b = ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
      p = longint'(a) * longint'(b);
      beat(p, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_rdy = 1'b0;
    bus.out_ready = 1'b1;
    beat(64'd0, 1);
    idle(5);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_results actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Streaming signed accumulator downstream of the 32x32 signed combinational multiplier.
- Consumes one 64-bit signed product per handshake and sums the products of a group (dot product) in a wide guard-bit accumulator.
- Emits one saturated 64-bit signed result per group through a valid/ready output register.
- Sits between the multiplier and the result writeback/consumer stage.

Parameters:
- ACC_W, 72, accumulator width in bits; must be at least 64 + clog2(MAX_TERMS).
- MAX_TERMS, 256, maximum terms per group; the term that reaches this count force-closes the group.
- CNT_W, 16, width of out_count; must be at least clog2(MAX_TERMS+1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  product beat valid
- in_ready  output  1  block accepts beat; combinational: ~out_valid | out_ready
- in_product  input  64  signed two's-complement product
- in_last  input  1  beat is the final term of the current group
- out_valid  output  1  group result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  64  saturated signed group sum
- out_count  output  CNT_W  number of terms in the group
- out_sat  output  1  sum was clamped to 64-bit range
- out_trunc  output  1  group closed by MAX_TERMS, not by in_last

Behaviour:
- Reset (async assert, sync-release usage): acc=0, cnt=0, state=EMPTY, out_valid=0, out_sum=0, out_count=0, out_sat=0, out_trunc=0. Reset mid-group discards the partial sum; no result is emitted.
- Accept condition: in_valid & in_ready.
- States: EMPTY (no partial sum) and ACCUM (partial sum held).
- EMPTY + accept: acc_next = sext(in_product); cnt_next = 1.
- ACCUM + accept: acc_next = acc + sext(in_product); cnt_next = cnt + 1.
- close = accept & (in_last | cnt_next == MAX_TERMS).
- On close:
  - out_sum <= sat64(acc_next); out_sat <= (acc_next outside [-2^63, 2^63-1]).
  - out_trunc <= ~in_last; out_count <= cnt_next.
  - out_valid <= 1; state <= EMPTY; acc <= 0; cnt <= 0.
- Accept without close: state <= ACCUM; acc and cnt take their next values.
- Latency: 1 cycle from the closing beat to out_valid high.
- Output hold: out_valid stays high and out_* stay stable until out_ready. When out_valid & out_ready and there is no close in that cycle, out_valid <= 0 and the data fields hold their last values.
- Simultaneous drain and close: if out_valid & out_ready and a close occur in the same cycle, the new result loads and out_valid stays 1. Full throughput of one group per cycle is possible with single-term groups.
- Backpressure: out_valid & ~out_ready forces in_ready=0, so no beat is lost and acc is frozen.
- Overflow: the internal acc cannot overflow for ACC_W >= 64 + clog2(MAX_TERMS), since each product magnitude is at most 2^62. Saturation applies only on narrowing to 64 bits.
- sat64: positive overflow gives 0x7FFF_FFFF_FFFF_FFFF; negative overflow gives 0x8000_0000_0000_0000.
- in_valid=0 cycles inside a group are allowed; the partial sum is held indefinitely.
- out_count equal to 0 never occurs on a valid output.

Decomposition:
- Shared package mac_pkg holds:
  - state enum {EMPTY, ACCUM}
  - ACC_W and MAX_TERMS defaults
  - SAT_POS_64 / SAT_NEG_64 constants
- One sub-module, sat_narrow: combinational ACC_W-to-64 signed saturator with a sat flag output. The parent keeps the FSM, counter and output register.

Test Plan:
- Group 6, -10, 100 (last on the 3rd beat), out_ready=1 -> one cycle later out_valid=1, out_sum=96, out_count=3, out_sat=0, out_trunc=0.
- Four beats of 0x4000_0000_0000_0000 (2^62), last on the 4th -> out_sum=0x7FFF_FFFF_FFFF_FFFF, out_sat=1. Repeat with -2^62 x3 then -2^62 last (sum -2^64) -> out_sum=0x8000_0000_0000_0000, out_sat=1.
- Single-term groups 5,7,9 on back-to-back cycles with out_ready=1 -> out_sum 5,7,9 on consecutive cycles, out_count=1 each. Then hold out_ready=0 after the first result -> in_ready=0, out_sum stays 5 until out_ready rises, no beat dropped.
- MAX_TERMS=4: beats 1,1,1,1,1 with in_last only on the 5th -> first result out_sum=4, out_count=4, out_trunc=1. Second result out_sum=1, out_count=1, out_trunc=0.
- Beats 10, 20, then assert rst_n=0 mid-group for 1 cycle, release, then beat 3 with last -> out_sum=3, out_count=1. All outputs read 0 while in reset.
- Group 1000, in_valid low 5 cycles, -1 with last -> out_sum=999, out_count=2.
